// File: rtl/button_debouncer_if.sv
// ---------------------------------------------------------------------------
// button_debouncer_if
//   Bundles the button-side and controller-side signals of the push-button
//   conditioning stage.
//
//   btn_raw  : raw asynchronous button levels, 1 = pressed
//   db       : debounced level per button
//   scen     : single-cycle press pulse per button
//   any_scen : OR of scen, same cycle
//
//   Modports:
//     master : the side that owns the buttons and consumes the strobes
//     slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface button_debouncer_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] db;
  logic [N_BTN-1:0] scen;
  logic             any_scen;

  modport master (
    output btn_raw,
    input  db,
    input  scen,
    input  any_scen
  );

  modport slave (
    input  btn_raw,
    output db,
    output scen,
    output any_scen
  );
endinterface

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Conditions the board push-buttons for the tic-tac-toe controller. Each
//   raw button goes through a 2-flop synchronizer and an independent
//   debounce FSM that yields a clean level (db) and a one-clock press
//   strobe (scen). any_scen is the OR of all strobes.
//
//   Bit order of every vector: [0]=up [1]=down [2]=left [3]=right [4]=center
//
//   Ports:
//     clk  : system clock (single domain)
//     rst  : synchronous, active-high reset
//     bus  : button_debouncer_if.slave (btn_raw in; db, scen, any_scen out)
//
//   Optional feature: define AUTO_REPEAT_EN to make a held button emit a
//   first repeat strobe after HOLD_CYCLES and further strobes every
//   REPEAT_CYCLES. Without it, a held button yields exactly one strobe.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  button_debouncer_if.slave  bus
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PULSE       = 3'd2,
    HELD        = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Two-flop synchronizer; sync2_reg is the only copy the FSMs look at.
  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  logic [N_BTN-1:0] db_vec;
  logic [N_BTN-1:0] scen_vec;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             s;
    logic             db_bit;
    logic             scen_bit;
`ifdef AUTO_REPEAT_EN
    logic             rep_reg, rep_next;
`endif

    assign s = sync2_reg[gi];

    // State register
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
`ifdef AUTO_REPEAT_EN
        rep_reg   <= 1'b0;
`endif
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
`ifdef AUTO_REPEAT_EN
        rep_reg   <= rep_next;
`endif
      end
    end

    // Next-state logic. Every counting branch leaves its state at the
    // compare value, so cnt never runs past it and never wraps.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
`ifdef AUTO_REPEAT_EN
      rep_next   = rep_reg;
`endif
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
`ifdef AUTO_REPEAT_EN
          rep_next = 1'b0;
`endif
          if (s) state_next = DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!s) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next = PULSE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        PULSE: begin
          state_next = HELD;
          cnt_next   = '0;
        end
        HELD: begin
          if (!s) begin
            state_next = DEB_RELEASE;
            cnt_next   = '0;
          end else begin
`ifdef AUTO_REPEAT_EN
            // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
            if (!rep_reg && cnt_reg == HOLD_LAST) begin
              state_next = PULSE;
              rep_next   = 1'b1;
            end else if (rep_reg && cnt_reg == REP_LAST) begin
              state_next = PULSE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
`endif
          end
        end
        DEB_RELEASE: begin
          if (s) begin
            // Release bounce: back to HELD without a new strobe.
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Output decode: purely from state, no path from btn_raw.
    always_comb begin
      scen_bit = (state_reg == PULSE);
      db_bit   = (state_reg == PULSE) || (state_reg == HELD) ||
                 (state_reg == DEB_RELEASE);
    end

    assign db_vec[gi]   = db_bit;
    assign scen_vec[gi] = scen_bit;
  end

  assign bus.db       = db_vec;
  assign bus.scen     = scen_vec;
  assign bus.any_scen = |scen_vec;

endmodule
